// File: rtl/macc_vec_if.sv
// Streaming handshake bundle for the macc_vec dot-product engine: operand beat in, accumulated result out.
interface macc_vec_if #(
  parameter int SIZEIN  = 16,
  parameter int LANES   = 4,
  parameter int SIZEOUT = 40,
  parameter int CNTW    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*SIZEIN-1:0]   in_a;
  logic [LANES*SIZEIN-1:0]   in_b;
  logic                      in_signed;
  logic                      in_first;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [SIZEOUT-1:0]        out_accum;
  logic [CNTW-1:0]           out_beats;
  logic                      out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_accum, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_first, in_last, out_ready,
    output in_ready, out_valid, out_accum, out_beats, out_ovf
  );
endinterface

// File: rtl/macc_vec.sv
// Multi-lane streaming multiply-accumulate: S1 operands, S2 products, S3 adder tree, S4 accumulator,
// then a result register held under backpressure. Any output stall freezes the whole pipeline.
module macc_vec #(
  parameter int SIZEIN  = 16,
  parameter int LANES   = 4,
  parameter int SIZEOUT = 40,
  parameter int SAT     = 1,
  parameter int CNTW    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  macc_vec_if.slave   bus
);
  localparam int LG = $clog2(LANES);
  localparam int PW = 2*SIZEIN + 2;
  localparam int TW = PW + LG;
  // Working width wide enough for both the tree sum and one accumulator carry.
  localparam int AW = ((TW > SIZEOUT) ? TW : SIZEOUT) + 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-SIZEOUT+1){1'b0}}, {(SIZEOUT-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-SIZEOUT+1){1'b1}}, {(SIZEOUT-1){1'b0}}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic                      adv_s;
  logic                      v1_r, sgn1_r, first1_r, last1_r;
  logic [LANES*SIZEIN-1:0]   a1_r, b1_r;
  logic signed [PW-1:0]      prod_s [LANES];
  logic signed [PW-1:0]      prod_r [LANES];
  logic                      v2_r, first2_r, last2_r;
  logic signed [TW-1:0]      sum_s, sum_r;
  logic                      v3_r, first3_r, last3_r;
  logic                      load_s, ovf_s, ovf_nxt_s;
  logic signed [AW-1:0]      base_s, true_s;
  logic signed [SIZEOUT-1:0] acc_nxt_s, acc_r;
  logic [CNTW-1:0]           cnt_nxt_s, cnt_r;
  logic                      ovf_r, need_load_r, v4_r, last4_r;
  logic                      out_valid_r, out_ovf_r;
  logic [SIZEOUT-1:0]        out_accum_r;
  logic [CNTW-1:0]           out_beats_r;

  assign adv_s         = ~(out_valid_r & ~bus.out_ready);
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_accum = out_accum_r;
  assign bus.out_beats = out_beats_r;
  assign bus.out_ovf   = out_ovf_r;

  // S1: capture operands and beat flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      sgn1_r   <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
      a1_r     <= '0;
      b1_r     <= '0;
    end else if (adv_s) begin
      v1_r     <= bus.in_valid;
      sgn1_r   <= bus.in_signed;
      first1_r <= bus.in_first;
      last1_r  <= bus.in_last;
      a1_r     <= bus.in_a;
      b1_r     <= bus.in_b;
    end
  end

  // Per-lane product of (SIZEIN+1)-bit extended operands.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = PW'($signed({sgn1_r & a1_r[i*SIZEIN+SIZEIN-1], a1_r[i*SIZEIN +: SIZEIN]}))
                * PW'($signed({sgn1_r & b1_r[i*SIZEIN+SIZEIN-1], b1_r[i*SIZEIN +: SIZEIN]}));
    end
  end

  // S2: register the lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r     <= 1'b0;
      first2_r <= 1'b0;
      last2_r  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_r[i] <= '0;
    end else if (adv_s) begin
      v2_r     <= v1_r;
      first2_r <= first1_r;
      last2_r  <= last1_r;
      for (int i = 0; i < LANES; i++) prod_r[i] <= prod_s[i];
    end
  end

  // Full-precision lane sum.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) sum_s = sum_s + TW'(prod_r[i]);
  end

  // S3: register the tree sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r     <= 1'b0;
      first3_r <= 1'b0;
      last3_r  <= 1'b0;
      sum_r    <= '0;
    end else if (adv_s) begin
      v3_r     <= v2_r;
      first3_r <= first2_r;
      last3_r  <= last2_r;
      sum_r    <= sum_s;
    end
  end

  // Next accumulator value with range check, clamp-or-wrap, and beat count update.
  always_comb begin
    load_s = first3_r | need_load_r;
    if (load_s) begin
      base_s = '0;
    end else begin
      base_s = AW'(acc_r);
    end
    true_s = base_s + AW'(sum_r);
    ovf_s  = (true_s > MAXV) || (true_s < MINV);
    if (ovf_s && (SAT != 0)) begin
      if (true_s[AW-1]) begin
        acc_nxt_s = MINV[SIZEOUT-1:0];
      end else begin
        acc_nxt_s = MAXV[SIZEOUT-1:0];
      end
    end else begin
      acc_nxt_s = true_s[SIZEOUT-1:0];
    end
    if (load_s) begin
      cnt_nxt_s = CNT_ONE;
      ovf_nxt_s = ovf_s;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_r | ovf_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
      ovf_nxt_s = ovf_r | ovf_s;
    end
  end

  // S4: accumulator; need_load_r makes the beat after reset or after a last beat start fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
      need_load_r <= 1'b1;
      v4_r        <= 1'b0;
      last4_r     <= 1'b0;
    end else if (adv_s) begin
      v4_r    <= v3_r;
      last4_r <= last3_r;
      if (v3_r) begin
        acc_r       <= acc_nxt_s;
        cnt_r       <= cnt_nxt_s;
        ovf_r       <= ovf_nxt_s;
        need_load_r <= last3_r;
      end
    end
  end

  // Result register: loads on a completed vector, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_accum_r <= '0;
      out_beats_r <= '0;
      out_ovf_r   <= 1'b0;
    end else if (adv_s) begin
      if (v4_r && last4_r) begin
        out_valid_r <= 1'b1;
        out_accum_r <= acc_r;
        out_beats_r <= cnt_r;
        out_ovf_r   <= ovf_r;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_macc_vec.sv
// Directed bench for macc_vec: default instance plus two SIZEOUT=34 instances (saturating, wrapping).
module tb_macc_vec;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 clk = ~clk;

  macc_vec_if #(.SIZEIN(16), .LANES(4), .SIZEOUT(40), .CNTW(16)) bm ();
  macc_vec_if #(.SIZEIN(16), .LANES(4), .SIZEOUT(34), .CNTW(16)) bs ();
  macc_vec_if #(.SIZEIN(16), .LANES(4), .SIZEOUT(34), .CNTW(16)) bw ();

  macc_vec #(.SIZEIN(16), .LANES(4), .SIZEOUT(40), .SAT(1), .CNTW(16)) u_main (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
  macc_vec #(.SIZEIN(16), .LANES(4), .SIZEOUT(34), .SAT(1), .CNTW(16)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
  macc_vec #(.SIZEIN(16), .LANES(4), .SIZEOUT(34), .SAT(0), .CNTW(16)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bw.slave));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    rep = {v, v, v, v};
  endfunction

  task automatic set_in(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                        input logic first, input logic last, input logic valid);
    bm.in_a = a; bm.in_b = b; bm.in_signed = sgn; bm.in_first = first; bm.in_last = last; bm.in_valid = valid;
    bs.in_a = a; bs.in_b = b; bs.in_signed = sgn; bs.in_first = first; bs.in_last = last; bs.in_valid = valid;
    bw.in_a = a; bw.in_b = b; bw.in_signed = sgn; bw.in_first = first; bw.in_last = last; bw.in_valid = valid;
  endtask

  task automatic set_ready(input logic r);
    bm.out_ready = r;
    bs.out_ready = r;
    bw.out_ready = r;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                      input logic first, input logic last);
    int n = 0;
    set_in(a, b, sgn, first, last, 1'b1);
    while (!bm.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", longint'(bm.in_ready), 64'sd1);
    @(negedge clk);
    set_in(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bm.out_valid && cycles < 40);
    check("out_valid_seen", longint'(bm.out_valid), 64'sd1);
  endtask

  task automatic chk_out(input string tag, input longint acc, input longint beats, input longint ovf);
    check({tag, "_acc"},   longint'($signed(bm.out_accum)), acc);
    check({tag, "_beats"}, longint'(bm.out_beats), beats);
    check({tag, "_ovf"},   longint'(bm.out_ovf), ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_in(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("rst_valid", longint'(bm.out_valid), 64'sd0);
    chk_out("rst", 64'sd0, 64'sd0, 64'sd0);
    check("rst_in_ready", longint'(bm.in_ready), 64'sd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat vector, latency 4.
    send({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    check("t1_latency", longint'(lat), 64'sd4);
    chk_out("t1", 64'sd70, 64'sd1, 64'sd0);
    @(negedge clk);
    check("t1_valid_drop", longint'(bm.out_valid), 64'sd0);

    // Three-beat negative vector followed back-to-back by a single beat.
    send(rep(16'hFFFD), rep(16'd2), 1'b1, 1'b1, 1'b0);
    send(rep(16'hFFFD), rep(16'd2), 1'b1, 1'b0, 1'b0);
    send(rep(16'hFFFD), rep(16'd2), 1'b1, 1'b0, 1'b1);
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    chk_out("t2a", -64'sd72, 64'sd3, 64'sd0);
    @(negedge clk);
    check("t2b_valid", longint'(bm.out_valid), 64'sd1);
    chk_out("t2b", 64'sd4, 64'sd1, 64'sd0);

    // Unsigned versus signed interpretation of all-ones operands.
    send(rep(16'hFFFF), rep(16'hFFFF), 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    chk_out("t3_unsigned", 64'sd17179344900, 64'sd1, 64'sd0);
    send(rep(16'hFFFF), rep(16'hFFFF), 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    chk_out("t3_signed", 64'sd4, 64'sd1, 64'sd0);

    // Overflow at SIZEOUT=34: clamp vs wrap; the 40-bit instance holds the exact value.
    send(rep(16'h8000), rep(16'h8000), 1'b1, 1'b1, 1'b0);
    send(rep(16'h8000), rep(16'h8000), 1'b1, 1'b0, 1'b1);
    wait_out(lat);
    chk_out("t4_main", 64'sd8589934592, 64'sd2, 64'sd0);
    check("t4_sat_acc",  longint'($signed(bs.out_accum)), 64'sd8589934591);
    check("t4_sat_ovf",  longint'(bs.out_ovf), 64'sd1);
    check("t4_sat_beats", longint'(bs.out_beats), 64'sd2);
    check("t4_wrap_acc", longint'($signed(bw.out_accum)), -64'sd8589934592);
    check("t4_wrap_ovf", longint'(bw.out_ovf), 64'sd1);
    @(negedge clk);

    // Backpressure: three results queue up; a beat offered while stalled must be ignored.
    set_ready(1'b0);
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b1);
    send(rep(16'd2), rep(16'd1), 1'b1, 1'b1, 1'b1);
    send(rep(16'd3), rep(16'd1), 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("bp_in_ready", longint'(bm.in_ready), 64'sd0);
    check("bp_valid", longint'(bm.out_valid), 64'sd1);
    check("bp_acc_hold1", longint'($signed(bm.out_accum)), 64'sd4);
    set_in(rep(16'd9), rep(16'd1), 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    set_in(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready2", longint'(bm.in_ready), 64'sd0);
    check("bp_acc_hold2", longint'($signed(bm.out_accum)), 64'sd4);
    set_ready(1'b1);
    check("bp_r1_valid", longint'(bm.out_valid), 64'sd1);
    chk_out("bp_r1", 64'sd4, 64'sd1, 64'sd0);
    @(negedge clk);
    check("bp_r2_valid", longint'(bm.out_valid), 64'sd1);
    chk_out("bp_r2", 64'sd8, 64'sd1, 64'sd0);
    @(negedge clk);
    check("bp_r3_valid", longint'(bm.out_valid), 64'sd1);
    chk_out("bp_r3", 64'sd12, 64'sd1, 64'sd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_no_extra", longint'(bm.out_valid), 64'sd0);
    end

    // Reset in the middle of a four-beat vector.
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b0);
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", longint'(bm.out_valid), 64'sd0);
    chk_out("mid_rst", 64'sd0, 64'sd0, 64'sd0);
    check("mid_rst_in_ready", longint'(bm.in_ready), 64'sd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    check("post_rst_latency", longint'(lat), 64'sd4);
    chk_out("post_rst", 64'sd4, 64'sd1, 64'sd0);

    // Beat after a last beat loads even without in_first.
    send(rep(16'd2), rep(16'd1), 1'b1, 1'b0, 1'b1);
    wait_out(lat);
    chk_out("after_last", 64'sd8, 64'sd1, 64'sd0);

    // in_first mid-vector silently abandons the partial sum.
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b0);
    send(rep(16'd3), rep(16'd1), 1'b1, 1'b1, 1'b1);
    wait_out(lat);
    chk_out("abandon", 64'sd12, 64'sd1, 64'sd0);
    @(negedge clk);
    check("abandon_single", longint'(bm.out_valid), 64'sd0);

    // Bubbles between beats leave the accumulator intact.
    send(rep(16'd1), rep(16'd1), 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send(rep(16'd2), rep(16'd1), 1'b1, 1'b0, 1'b1);
    wait_out(lat);
    chk_out("bubble", 64'sd12, 64'sd2, 64'sd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
